// File: rtl/traffic_phase_controller.sv
// ----------------------------------------------------------------------------
// traffic_phase_controller
//   Two-road (NS/EW) intersection sequencer. It provides configurable phase
//   durations, all-red clearance intervals, a latched pedestrian request that
//   is served by a dedicated walk phase, and a flash (night) mode. Flash mode
//   is entered only at the all-red boundaries.
//
// Ports:
//   clk          in   system clock, rising edge
//   reset        in   synchronous active-high reset, overrides everything
//   ped_req      in   pedestrian button (pulse or level), latched internally
//   flash_mode   in   level request for flash operation
//   NS, EW       out  one-hot lamps {R,Y,G}: 100 red, 010 yellow, 001 green,
//                     000 dark
//   walk         out  pedestrian walk lamp
//   phase        out  current state code (NSG=0 .. FLASH=7)
//   ped_pending  out  a latched pedestrian request is waiting
//
// All outputs are registered. They are decoded from the next state, so they
// change on the same edge that enters a state.
// ----------------------------------------------------------------------------
module traffic_phase_controller #(
  parameter int CNT_W    = 4,
  parameter int T_GREEN  = 5,
  parameter int T_YELLOW = 2,
  parameter int T_ALLRED = 1,
  parameter int T_WALK   = 4,
  parameter int T_FLASH  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ped_req,
  input  logic       flash_mode,
  output logic [2:0] NS,
  output logic [2:0] EW,
  output logic       walk,
  output logic [2:0] phase,
  output logic       ped_pending
);

  localparam int T_MAX = (1 << CNT_W) - 1;

  // Reject durations of zero or durations that do not fit in the timer.
  if ((T_GREEN  < 1) || (T_GREEN  > T_MAX) ||
      (T_YELLOW < 1) || (T_YELLOW > T_MAX) ||
      (T_ALLRED < 1) || (T_ALLRED > T_MAX) ||
      (T_WALK   < 1) || (T_WALK   > T_MAX) ||
      (T_FLASH  < 1) || (T_FLASH  > T_MAX)) begin : g_bad_param
    $error("traffic_phase_controller: illegal T_* parameter for CNT_W");
  end

  typedef enum logic [2:0] {
    NSG   = 3'd0,
    NSY   = 3'd1,
    AR1   = 3'd2,
    EWG   = 3'd3,
    EWY   = 3'd4,
    AR2   = 3'd5,
    WALK  = 3'd6,
    FLASH = 3'd7
  } state_t;

  localparam logic [2:0] LAMP_R   = 3'b100;
  localparam logic [2:0] LAMP_Y   = 3'b010;
  localparam logic [2:0] LAMP_G   = 3'b001;
  localparam logic [2:0] LAMP_OFF = 3'b000;

  // Terminal timer values: a state is left when the timer reaches T-1.
  localparam logic [CNT_W-1:0] G_LAST  = CNT_W'(T_GREEN - 1);
  localparam logic [CNT_W-1:0] Y_LAST  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] AR_LAST = CNT_W'(T_ALLRED - 1);
  localparam logic [CNT_W-1:0] W_LAST  = CNT_W'(T_WALK - 1);
  localparam logic [CNT_W-1:0] F_LAST  = CNT_W'(T_FLASH - 1);
  localparam logic [CNT_W-1:0] T_ZERO  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE   = CNT_W'(1);

  state_t           state_r, state_next_s;
  logic [CNT_W-1:0] timer_r, timer_next_s;
  logic             flash_on_r, flash_on_next_s;
  logic             ped_next_s;
  logic [2:0]       ns_next_s, ew_next_s;
  logic             walk_next_s;

  // Next-state, timer, flash-lamp flag and pedestrian latch.
  always_comb begin
    state_next_s    = state_r;
    timer_next_s    = timer_r + T_ONE;
    flash_on_next_s = flash_on_r;
    ped_next_s      = ped_pending;

    case (state_r)
      NSG: begin
        if (timer_r == G_LAST) state_next_s = NSY;
        else                   state_next_s = NSG;
      end
      NSY: begin
        if (timer_r == Y_LAST) state_next_s = AR1;
        else                   state_next_s = NSY;
      end
      AR1: begin
        if (timer_r == AR_LAST) begin
          if (flash_mode) state_next_s = FLASH;
          else            state_next_s = EWG;
        end else begin
          state_next_s = AR1;
        end
      end
      EWG: begin
        if (timer_r == G_LAST) state_next_s = EWY;
        else                   state_next_s = EWG;
      end
      EWY: begin
        if (timer_r == Y_LAST) state_next_s = AR2;
        else                   state_next_s = EWY;
      end
      AR2: begin
        if (timer_r == AR_LAST) begin
          // ped_req is included directly so that a press on the exit cycle
          // is served immediately.
          if (flash_mode)                   state_next_s = FLASH;
          else if (ped_pending || ped_req)  state_next_s = WALK;
          else                              state_next_s = NSG;
        end else begin
          state_next_s = AR2;
        end
      end
      WALK: begin
        if (timer_r == W_LAST) state_next_s = NSG;
        else                   state_next_s = WALK;
      end
      FLASH: begin
        // No minimum dwell: leave as soon as the request drops.
        if (!flash_mode) state_next_s = AR2;
        else             state_next_s = FLASH;
      end
      default: state_next_s = NSG;
    endcase

    // The timer restarts on every transition. Inside FLASH it also restarts
    // every half-period, and the lamp flag toggles at that point.
    if (state_next_s != state_r) begin
      timer_next_s = T_ZERO;
      if (state_next_s == FLASH) flash_on_next_s = 1'b1;
      else                       flash_on_next_s = flash_on_r;
    end else if ((state_r == FLASH) && (timer_r == F_LAST)) begin
      timer_next_s    = T_ZERO;
      flash_on_next_s = ~flash_on_r;
    end else begin
      timer_next_s    = timer_r + T_ONE;
      flash_on_next_s = flash_on_r;
    end

    // Entering WALK serves the request. This clear wins over a simultaneous
    // press.
    if ((state_next_s == WALK) && (state_r != WALK)) ped_next_s = 1'b0;
    else if (ped_req)                                ped_next_s = 1'b1;
    else                                             ped_next_s = ped_pending;
  end

  // Lamp decode from the next state, so that the registered lamps track
  // state entry.
  always_comb begin
    ns_next_s   = LAMP_R;
    ew_next_s   = LAMP_R;
    walk_next_s = 1'b0;
    case (state_next_s)
      NSG:   begin ns_next_s = LAMP_G; ew_next_s = LAMP_R; end
      NSY:   begin ns_next_s = LAMP_Y; ew_next_s = LAMP_R; end
      EWG:   begin ns_next_s = LAMP_R; ew_next_s = LAMP_G; end
      EWY:   begin ns_next_s = LAMP_R; ew_next_s = LAMP_Y; end
      WALK:  begin ns_next_s = LAMP_R; ew_next_s = LAMP_R; walk_next_s = 1'b1; end
      FLASH: begin
        if (flash_on_next_s) begin ns_next_s = LAMP_Y;   ew_next_s = LAMP_R;   end
        else                 begin ns_next_s = LAMP_OFF; ew_next_s = LAMP_OFF; end
      end
      default: begin ns_next_s = LAMP_R; ew_next_s = LAMP_R; end
    endcase
  end

  // State, timer and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= NSG;
      timer_r     <= T_ZERO;
      flash_on_r  <= 1'b1;
      ped_pending <= 1'b0;
      NS          <= LAMP_G;
      EW          <= LAMP_R;
      walk        <= 1'b0;
      phase       <= 3'd0;
    end else begin
      state_r     <= state_next_s;
      timer_r     <= timer_next_s;
      flash_on_r  <= flash_on_next_s;
      ped_pending <= ped_next_s;
      NS          <= ns_next_s;
      EW          <= ew_next_s;
      walk        <= walk_next_s;
      phase       <= state_next_s;
    end
  end

endmodule
